vend_sequencer: RTL and testbench

Transaction controller for the coin-operated vending path. It accumulates nickel/dime credit, asserts the dispense door (open) when the price is met, and waits for a mechanical acknowledge. It then returns change one nickel per cycle, and handles cancel, inactivity refund and coin rejection. It sits between the coin sensors, the dispense actuator and the change hopper.

---
 rtl/vend_sequencer.sv | 168 ++++++++++++++++
 tb/tb_vend_sequencer.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer.sv
// ---------------------------------------------------------------------------
// vend_sequencer
//
// Transaction controller for the coin-operated vending path. Accumulates
// nickel/dime credit, opens the dispense door once the price is covered,
// waits for the mechanism to acknowledge, then pays back any surplus one
// nickel per cycle. Also handles customer cancel, inactivity refund and
// rejection of coins that cannot be accepted.
//
// Ports:
//   clk          system clock, rising edge active
//   rst          asynchronous active-high reset
//   N            nickel inserted (one-cycle pulse, 5 cents)
//   D            dime inserted (one-cycle pulse, 10 cents)
//   cancel       customer refund request, level-sampled
//   vend_ack     dispense mechanism done (door closed)
//   open         dispense door enable, high while vending
//   change_n     return one nickel this cycle, high while paying change
//   coin_reject  registered pulse: the previous cycle's coin was refused
//   credit       current credit in cents
//   busy         high whenever a transaction is in progress
// ---------------------------------------------------------------------------
module vend_sequencer #(
  parameter int PRICE          = 15,
  parameter int MAX_CREDIT     = 35,
  parameter int CREDIT_W       = 6,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                N,
  input  logic                D,
  input  logic                cancel,
  input  logic                vend_ack,
  output logic                open,
  output logic                change_n,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   PRICE_W  = (CREDIT_W + 1)'(PRICE);
  localparam logic [CREDIT_W:0]   MAX_W    = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] NICKEL   = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] DIME     = CREDIT_W'(10);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  state_t              state, state_nx;
  logic [CREDIT_W-1:0] credit_nx;
  logic [TMR_W-1:0]    tmr, tmr_nx;
  logic                reject_nx;

  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   sum;
  logic                has_coin;
  logic                idle_ok;
  logic                collect_ok;

  // Coin value this cycle; both sensors together are worth 15.
  assign coin_val   = (N ? NICKEL : '0) + (D ? DIME : '0);
  assign has_coin   = N | D;
  // One extra bit so the ceiling comparison cannot wrap.
  assign sum        = {1'b0, credit} + {1'b0, coin_val};
  // Credit is always zero in IDLE, so the first coin is judged on its own.
  assign idle_ok    = ({1'b0, coin_val} <= MAX_W);
  assign collect_ok = has_coin && (sum <= MAX_W);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nx  = state;
    credit_nx = credit;
    tmr_nx    = tmr;
    reject_nx = 1'b0;

    unique case (state)
      IDLE: begin
        tmr_nx = '0;
        // cancel has nothing to refund here and is ignored.
        if (has_coin) begin
          if (idle_ok) begin
            credit_nx = coin_val;
            state_nx  = (coin_val >= PRICE_C) ? VEND : COLLECT;
          end else begin
            reject_nx = 1'b1;
          end
        end
      end

      COLLECT: begin
        if (collect_ok) begin
          credit_nx = sum[CREDIT_W-1:0];
          tmr_nx    = '0;
        end else begin
          // A refused coin does not count as activity for the idle timer.
          reject_nx = has_coin;
          tmr_nx    = tmr + 1'b1;
        end

        // An accepted coin is applied before cancel/timeout are considered,
        // so meeting the price always wins.
        if (collect_ok && (sum >= PRICE_W)) begin
          state_nx = VEND;
        end else if (cancel || (!collect_ok && (tmr == TMR_LAST))) begin
          state_nx = CHANGE;
          tmr_nx   = '0;
        end
      end

      VEND: begin
        reject_nx = has_coin;
        if (vend_ack) begin
          credit_nx = credit - PRICE_C;
          state_nx  = (credit > PRICE_C) ? CHANGE : IDLE;
        end
      end

      CHANGE: begin
        reject_nx = has_coin;
        // Guarded with <= so a corrupted credit can never underflow.
        if (credit <= NICKEL) begin
          credit_nx = '0;
          state_nx  = IDLE;
        end else begin
          credit_nx = credit - NICKEL;
        end
      end

      default: begin
        state_nx  = IDLE;
        credit_nx = '0;
        tmr_nx    = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      credit      <= '0;
      tmr         <= '0;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_nx;
      credit      <= credit_nx;
      tmr         <= tmr_nx;
      coin_reject <= reject_nx;
    end
  end

  // Moore outputs decoded from the state register only.
  assign open     = (state == VEND);
  assign change_n = (state == CHANGE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_vend_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vend_sequencer
//
// Self-checking bench for vend_sequencer. A default-parameter instance runs
// directed scenarios and randomized transactions; a second instance with a
// price above the credit ceiling exercises coin rejection while collecting.
// ---------------------------------------------------------------------------
module tb_vend_sequencer;

  localparam int PRICE    = 15;
  localparam int MAX_CRED = 35;
  localparam int CW       = 6;
  localparam int TIMEOUT  = 16;

  logic          clk;
  logic          rst;
  logic          n, d, cancel, vend_ack;
  logic          open, change_n, coin_reject, busy;
  logic [CW-1:0] credit;

  logic          n2, d2, cancel2, ack2;
  logic          open2, change_n2, coin_reject2, busy2;
  logic [CW-1:0] credit2;

  int checks;
  int fails;

  vend_sequencer #(
    .PRICE(PRICE), .MAX_CREDIT(MAX_CRED), .CREDIT_W(CW), .TIMEOUT_CYCLES(TIMEOUT)
  ) u_dut (
    .clk(clk), .rst(rst), .N(n), .D(d), .cancel(cancel), .vend_ack(vend_ack),
    .open(open), .change_n(change_n), .coin_reject(coin_reject),
    .credit(credit), .busy(busy)
  );

  vend_sequencer #(
    .PRICE(40), .MAX_CREDIT(35), .CREDIT_W(CW), .TIMEOUT_CYCLES(TIMEOUT)
  ) u_dut40 (
    .clk(clk), .rst(rst), .N(n2), .D(d2), .cancel(cancel2), .vend_ack(ack2),
    .open(open2), .change_n(change_n2), .coin_reject(coin_reject2),
    .credit(credit2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Advance one clock and sample outputs shortly after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic nn, input logic dd, input logic cc, input logic aa);
    n = nn; d = dd; cancel = cc; vend_ack = aa;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0);
    n2 = 0; d2 = 0; cancel2 = 0; ack2 = 0;
    #12;
    checks++;
    if ({open, change_n, coin_reject, busy, credit} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got open=%b chg=%b rej=%b busy=%b credit=%0d, want all 0",
               open, change_n, coin_reject, busy, credit);
    end
    checks++;
    if ({open2, change_n2, coin_reject2, busy2, credit2} !== '0) begin
      fails++;
      $display("FAIL reset_outputs_40: got busy=%b credit=%0d, want all 0", busy2, credit2);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_exact_price();
    drive(1, 0, 0, 0); tick(); drive(0, 0, 0, 0);
    checks++;
    if ({busy, open, credit} !== {1'b1, 1'b0, CW'(5)}) begin
      fails++; $display("FAIL exact_first_nickel: busy=%b open=%b credit=%0d, want 1 0 5", busy, open, credit);
    end
    tick();
    checks++;
    if (credit !== CW'(5)) begin
      fails++; $display("FAIL exact_gap: credit=%0d, want 5", credit);
    end
    drive(0, 1, 0, 0); tick(); drive(0, 0, 0, 0);
    checks++;
    if ({open, credit} !== {1'b1, CW'(15)}) begin
      fails++; $display("FAIL exact_open: open=%b credit=%0d, want 1 15", open, credit);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({open, change_n, credit} !== {1'b1, 1'b0, CW'(15)}) begin
        fails++; $display("FAIL exact_hold%0d: open=%b chg=%b credit=%0d, want 1 0 15", i, open, change_n, credit);
      end
    end
    drive(0, 0, 0, 1); tick(); drive(0, 0, 0, 0);
    checks++;
    if ({open, change_n, busy, credit} !== {3'b000, CW'(0)}) begin
      fails++; $display("FAIL exact_ack: open=%b chg=%b busy=%b credit=%0d, want 0 0 0 0", open, change_n, busy, credit);
    end
    tick();
    checks++;
    if (change_n !== 1'b0) begin
      fails++; $display("FAIL exact_no_change: change_n=%b, want 0", change_n);
    end
  endtask

  task automatic test_overpay();
    drive(0, 1, 0, 0); tick();
    drive(0, 1, 0, 0); tick(); drive(0, 0, 0, 0);
    checks++;
    if ({open, credit} !== {1'b1, CW'(20)}) begin
      fails++; $display("FAIL overpay_open: open=%b credit=%0d, want 1 20", open, credit);
    end
    drive(0, 0, 0, 1); tick(); drive(0, 0, 0, 0);
    checks++;
    if ({open, change_n, credit} !== {1'b0, 1'b1, CW'(5)}) begin
      fails++; $display("FAIL overpay_change: open=%b chg=%b credit=%0d, want 0 1 5", open, change_n, credit);
    end
    tick();
    checks++;
    if ({change_n, busy, credit} !== {2'b00, CW'(0)}) begin
      fails++; $display("FAIL overpay_done: chg=%b busy=%b credit=%0d, want 0 0 0", change_n, busy, credit);
    end
  endtask

  task automatic test_simultaneous();
    drive(1, 1, 0, 0); tick(); drive(0, 0, 0, 0);
    checks++;
    if ({open, credit} !== {1'b1, CW'(15)}) begin
      fails++; $display("FAIL simul_open: open=%b credit=%0d, want 1 15", open, credit);
    end
    drive(0, 0, 0, 1); tick(); drive(0, 0, 0, 0);
    checks++;
    if ({change_n, busy, credit} !== {2'b00, CW'(0)}) begin
      fails++; $display("FAIL simul_ack: chg=%b busy=%b credit=%0d, want 0 0 0", change_n, busy, credit);
    end
  endtask

  task automatic test_cancel();
    drive(0, 0, 1, 0); tick(); drive(0, 0, 0, 0);
    checks++;
    if ({busy, change_n, credit} !== {2'b00, CW'(0)}) begin
      fails++; $display("FAIL cancel_idle: busy=%b chg=%b credit=%0d, want 0 0 0", busy, change_n, credit);
    end
    drive(1, 0, 0, 0); tick();
    drive(1, 0, 0, 0); tick(); drive(0, 0, 0, 0);
    checks++;
    if ({open, credit} !== {1'b0, CW'(10)}) begin
      fails++; $display("FAIL cancel_collect: open=%b credit=%0d, want 0 10", open, credit);
    end
    drive(0, 0, 1, 0); tick(); drive(0, 0, 0, 0);
    checks++;
    if ({open, change_n, credit} !== {1'b0, 1'b1, CW'(10)}) begin
      fails++; $display("FAIL cancel_chg1: open=%b chg=%b credit=%0d, want 0 1 10", open, change_n, credit);
    end
    tick();
    checks++;
    if ({open, change_n, credit} !== {1'b0, 1'b1, CW'(5)}) begin
      fails++; $display("FAIL cancel_chg2: open=%b chg=%b credit=%0d, want 0 1 5", open, change_n, credit);
    end
    tick();
    checks++;
    if ({change_n, busy, credit} !== {2'b00, CW'(0)}) begin
      fails++; $display("FAIL cancel_done: chg=%b busy=%b credit=%0d, want 0 0 0", change_n, busy, credit);
    end
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    drive(1, 0, 0, 0); tick(); drive(0, 0, 0, 0);
    // The refund must not start before the sixteenth idle cycle.
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      tick();
      if (change_n !== 1'b0 || busy !== 1'b1) early++;
    end
    checks++;
    if (early != 0) begin
      fails++; $display("FAIL timeout_early: %0d premature cycles, want 0", early);
    end
    tick();
    checks++;
    if ({change_n, credit} !== {1'b1, CW'(5)}) begin
      fails++; $display("FAIL timeout_refund: chg=%b credit=%0d, want 1 5", change_n, credit);
    end
    tick();
    checks++;
    if ({change_n, busy, credit} !== {2'b00, CW'(0)}) begin
      fails++; $display("FAIL timeout_done: chg=%b busy=%b credit=%0d, want 0 0 0", change_n, busy, credit);
    end
  endtask

  task automatic test_vend_reject();
    drive(0, 1, 0, 0); tick();
    drive(0, 1, 0, 0); tick();
    drive(1, 0, 0, 0); tick(); drive(0, 0, 0, 0);
    checks++;
    if ({coin_reject, open, credit} !== {2'b11, CW'(20)}) begin
      fails++; $display("FAIL vend_reject: rej=%b open=%b credit=%0d, want 1 1 20", coin_reject, open, credit);
    end
    tick();
    checks++;
    if ({coin_reject, credit} !== {1'b0, CW'(20)}) begin
      fails++; $display("FAIL vend_reject_pulse: rej=%b credit=%0d, want 0 20", coin_reject, credit);
    end
    drive(0, 0, 0, 1); tick(); drive(0, 0, 0, 0);
    tick();
    checks++;
    if ({busy, credit} !== {1'b0, CW'(0)}) begin
      fails++; $display("FAIL vend_reject_done: busy=%b credit=%0d, want 0 0", busy, credit);
    end
  endtask

  task automatic test_max_credit();
    int pulses;
    int cyc;
    for (int i = 0; i < 3; i++) begin
      d2 = 1'b1; tick();
    end
    d2 = 1'b0;
    checks++;
    if ({busy2, open2, credit2} !== {2'b10, CW'(30)}) begin
      fails++; $display("FAIL max_collect: busy=%b open=%b credit=%0d, want 1 0 30", busy2, open2, credit2);
    end
    d2 = 1'b1; tick(); d2 = 1'b0;
    checks++;
    if ({coin_reject2, credit2} !== {1'b1, CW'(30)}) begin
      fails++; $display("FAIL max_reject: rej=%b credit=%0d, want 1 30", coin_reject2, credit2);
    end
    tick();
    checks++;
    if ({coin_reject2, credit2} !== {1'b0, CW'(30)}) begin
      fails++; $display("FAIL max_reject_pulse: rej=%b credit=%0d, want 0 30", coin_reject2, credit2);
    end
    cancel2 = 1'b1; tick(); cancel2 = 1'b0;
    pulses = 0;
    cyc = 0;
    while (busy2 === 1'b1 && cyc < 20) begin
      if (change_n2 === 1'b1) pulses++;
      tick();
      cyc++;
    end
    checks++;
    if (pulses != 6 || busy2 !== 1'b0 || credit2 !== CW'(0)) begin
      fails++; $display("FAIL max_refund: pulses=%0d busy=%b credit=%0d, want 6 0 0", pulses, busy2, credit2);
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 0, 0); tick();
    drive(0, 1, 0, 0); tick(); drive(0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({open, change_n, busy, credit} !== {3'b000, CW'(0)}) begin
      fails++; $display("FAIL reset_in_vend: open=%b chg=%b busy=%b credit=%0d, want all 0", open, change_n, busy, credit);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, 0, 0); tick();
    drive(0, 1, 0, 0); tick();
    drive(0, 0, 0, 1); tick(); drive(0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({open, change_n, busy, credit} !== {3'b000, CW'(0)}) begin
      fails++; $display("FAIL reset_in_change: open=%b chg=%b busy=%b credit=%0d, want all 0", open, change_n, busy, credit);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0, 0); tick(); drive(0, 0, 0, 0);
    checks++;
    if (credit !== CW'(5)) begin
      fails++; $display("FAIL reset_resume: credit=%0d, want 5", credit);
    end
    drive(0, 0, 1, 0); tick(); drive(0, 0, 0, 0);
    tick();
  endtask

  // Randomized transactions: the expected credit path is computed from the
  // pricing rules (accept under the ceiling, vend at price, refund surplus
  // in nickels) and compared every cycle.
  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      int  exp_credit;
      int  cv;
      int  idle_run;
      int  guard;
      bit  vending, refunding, exp_rej, first;
      logic nb, db, cb;

      exp_credit = 0;
      vending    = 0;
      refunding  = 0;
      first      = 1;
      idle_run   = 0;
      guard      = 0;

      while (!vending && !refunding && guard < 60) begin
        guard++;
        cb = 1'b0;
        if (first) begin
          nb = 1'($urandom_range(0, 1));
          db = 1'($urandom_range(0, 1));
          if (!nb && !db) nb = 1'b1;
          cb = 1'($urandom_range(0, 1));
        end else if (idle_run < 5 && $urandom_range(0, 2) == 0) begin
          nb = 1'b0; db = 1'b0;
          cb = ($urandom_range(0, 7) == 0);
        end else begin
          nb = 1'($urandom_range(0, 1));
          db = 1'($urandom_range(0, 1));
          if (!nb && !db) db = 1'b1;
          cb = ($urandom_range(0, 5) == 0);
        end
        cv = 5 * int'(nb) + 10 * int'(db);
        idle_run = (cv == 0) ? idle_run + 1 : 0;
        exp_rej = 0;
        if (first) begin
          exp_credit = cv;
          first = 0;
          vending = (exp_credit >= PRICE);
        end else begin
          if (cv > 0) begin
            if (exp_credit + cv <= MAX_CRED) exp_credit += cv;
            else exp_rej = 1;
          end
          if (exp_credit >= PRICE) vending = 1;
          else if (cb) refunding = 1;
        end
        drive(nb, db, cb, 0); tick(); drive(0, 0, 0, 0);
        checks++;
        if ({open, change_n, coin_reject, credit} !== {vending, refunding, exp_rej, CW'(exp_credit)}) begin
          fails++;
          $display("FAIL rand%0d_collect: open=%b chg=%b rej=%b credit=%0d, want %b %b %b %0d",
                   t, open, change_n, coin_reject, credit, vending, refunding, exp_rej, exp_credit);
        end
      end

      if (vending) begin
        int waits;
        waits = $urandom_range(0, 3);
        for (int w = 0; w <= waits; w++) begin
          logic ack;
          ack = (w == waits);
          nb = 1'($urandom_range(0, 1));
          db = ($urandom_range(0, 3) == 0);
          cb = 1'($urandom_range(0, 1));
          exp_rej = nb || db;
          if (ack) begin
            exp_credit -= PRICE;
            refunding = (exp_credit > 0);
          end
          drive(nb, db, cb, ack); tick(); drive(0, 0, 0, 0);
          checks++;
          if ({open, change_n, coin_reject, credit} !== {!ack, refunding, exp_rej, CW'(exp_credit)}) begin
            fails++;
            $display("FAIL rand%0d_vend: open=%b chg=%b rej=%b credit=%0d, want %b %b %b %0d",
                     t, open, change_n, coin_reject, credit, !ack, refunding, exp_rej, exp_credit);
          end
        end
      end

      guard = 0;
      while (refunding && guard < 20) begin
        guard++;
        nb = ($urandom_range(0, 2) == 0);
        db = ($urandom_range(0, 2) == 0);
        cb = 1'($urandom_range(0, 1));
        exp_rej = nb || db;
        exp_credit -= 5;
        refunding = (exp_credit > 0);
        drive(nb, db, cb, 0); tick(); drive(0, 0, 0, 0);
        checks++;
        if ({busy, change_n, coin_reject, credit} !== {refunding, refunding, exp_rej, CW'(exp_credit)}) begin
          fails++;
          $display("FAIL rand%0d_change: busy=%b chg=%b rej=%b credit=%0d, want %b %b %b %0d",
                   t, busy, change_n, coin_reject, credit, refunding, refunding, exp_rej, exp_credit);
        end
      end

      tick();
      checks++;
      if ({busy, coin_reject, credit} !== {2'b00, CW'(0)}) begin
        fails++;
        $display("FAIL rand%0d_idle: busy=%b rej=%b credit=%0d, want 0 0 0", t, busy, coin_reject, credit);
      end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_exact_price();
    test_overpay();
    test_simultaneous();
    test_cancel();
    test_timeout();
    test_vend_reject();
    test_max_credit();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
